axis_iq_pair_scheduler: RTL and testbench
=========================================

// Module: axis_iq_pair_scheduler
// PURPOSE
//  Sequences two independent AXIS sample lanes (I lane, Q lane) into one interleaved
//  stream tagged with tid (0 = I, 1 = Q). It feeds the interleave-to-continuous
//  converter, so that converter always receives complete, ordered I/Q pairs.
//  Samples are buffered per pair and emitted atomically; an I sample is dropped if
//  its Q partner misses a timeout. Single clock domain.
// PARAMETERS
//  DW         16   sample width per lane; must be a multiple of 8
//  TIMEOUT    64   max ce-cycles in WAIT_Q before the held I is dropped (>=2)
//  CNT_W      16   width of the pair and drop counters
// PORTS
//  aclk_s_i      in   1        clock
//  aresetn       in   1        reset: asynchronous, active-low
//  ce            in   1        clock enable; low freezes all state and outputs
//  clr_i         in   1        sync pulse: clears err_timeout_o, pair_cnt_o, drop_cnt_o
//  tdata_i_i     in   DW       I lane data
//  tvalid_i_i    in   1        I lane valid
//  tready_i_o    out  1        I lane ready
//  tdata_q_i     in   DW       Q lane data
//  tvalid_q_i    in   1        Q lane valid
//  tready_q_o    out  1        Q lane ready
//  tdata_m_o     out  DW       interleaved output data
//  tstrb_m_o     out  DW/8     output strobes; all ones whenever tvalid_m_o=1
//  tid_m_o       out  1        0 = I sample, 1 = Q sample
//  tvalid_m_o    out  1        output valid
//  tready_m_i    in   1        output ready
//  pair_cnt_o    out  CNT_W    pairs fully emitted, wraps modulo 2^CNT_W
//  drop_cnt_o    out  CNT_W    I samples dropped on timeout, saturates at all ones
//  err_timeout_o out  1        sticky; set on any drop
// BEHAVIOUR
//  Reset: state=WAIT_I; all outputs 0; hold registers and counters 0.
//  All transitions, counters and handshakes occur only on edges where ce=1.
//  When ce=0: tready_i_o=tready_q_o=0 (combinational), outputs hold value.
//  FSM (2-bit):
//   WAIT_I : tready_i_o=1. On I handshake: hold_i<=tdata_i_i, tmo<=0 -> WAIT_Q.
//   WAIT_Q : tready_q_o=1. On Q handshake: hold_q<=tdata_q_i; load output
//            {tdata=hold_i, tid=0, tvalid=1} -> EMIT_I.
//            Otherwise tmo++. When tmo==TIMEOUT-1 with no Q handshake in that cycle:
//            discard hold_i, drop_cnt++ (saturating), err_timeout_o<=1 -> WAIT_I.
//            A Q handshake in the timeout cycle takes priority (no drop).
//   EMIT_I : on output handshake load {hold_q, tid=1} -> EMIT_Q.
//   EMIT_Q : on output handshake: tvalid<=0, pair_cnt++ -> WAIT_I.
//  Outside these states the corresponding lane ready is 0; Q samples arriving
//  while in WAIT_I are back-pressured, never dropped.
//  Output is registered: AXIS rules hold; tdata/tid stable while tvalid & !tready.
//  Latency: Q handshake to first output valid = 1 cycle. With tready_m_i=1 a pair
//  costs 4 cycles (I accept, Q accept, emit I, emit Q).
//  clr_i coincident with an increment: clear wins; counters read 0 afterwards.
//  Reset mid-operation: held samples and in-flight output are discarded.
// STRUCTURE
//  Shared package/header: state encodings (ST_WAIT_I=0, ST_WAIT_Q=1, ST_EMIT_I=2,
//  ST_EMIT_Q=3), TID_I=0 / TID_Q=1 constants.
//  One sub-module: axis_pair_timeout_cnt (load/inc/expire counter, TIMEOUT param).
//  FSM, hold registers, output register and status counters stay in the top level.
// TESTING
//  1 Reset: all outputs 0 and tready_i_o=1 one cycle after aresetn=1 with ce=1.
//  2 I=0x1111 then Q=0x2222, tready_m_i=1 -> out 0x1111/tid0, 0x2222/tid1; pair_cnt=1.
//  3 tready_m_i=0 for 10 cycles in EMIT_I -> tdata=0x1111, tid=0 stable; lanes not ready.
//  4 I=0xAAAA, no Q for 64 cycles -> drop_cnt=1, err_timeout_o=1, no output; next
//    pair I=0x0001/Q=0x0002 emitted correctly.
//  5 Q presented first (0x5555), I 3 cycles later (0x6666) -> out I 0x6666 then Q 0x5555.
//  6 ce=0 mid EMIT_Q for 5 cycles -> lanes not ready, outputs frozen; resume after ce=1.

Source files
------------

// File: rtl/axis_iq_pair_scheduler_pkg.sv
// Shared encodings for the I/Q pair scheduler: FSM states and output tid values.
package axis_iq_pair_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_I = 2'd0,
    ST_WAIT_Q = 2'd1,
    ST_EMIT_I = 2'd2,
    ST_EMIT_Q = 2'd3
  } state_e;

  localparam logic TID_I = 1'b0;
  localparam logic TID_Q = 1'b1;

endpackage

// File: rtl/axis_iq_pair_scheduler_timeout_cnt.sv
// Wait-for-Q timeout counter: load clears, inc advances, expire flags the last allowed cycle.
module axis_pair_timeout_cnt #(
  parameter int TIMEOUT = 64,
  parameter int W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic aclk_s_i,
  input  logic aresetn,
  input  logic ce,
  input  logic load_i,
  input  logic inc_i,
  output logic expire_o
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ce) begin
      if (load_i) begin
        cnt_d = '0;
      end else if (inc_i && (cnt_q != LAST)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk_s_i or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/axis_iq_pair_scheduler.sv
// Interleaves independent I and Q AXIS lanes into atomic tid-tagged pairs,
// dropping a held I sample whose Q partner does not arrive in time.
module axis_iq_pair_scheduler
  import axis_iq_pair_scheduler_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              aclk_s_i,
  input  logic              aresetn,
  input  logic              ce,
  input  logic              clr_i,
  input  logic [DW-1:0]     tdata_i_i,
  input  logic              tvalid_i_i,
  output logic              tready_i_o,
  input  logic [DW-1:0]     tdata_q_i,
  input  logic              tvalid_q_i,
  output logic              tready_q_o,
  output logic [DW-1:0]     tdata_m_o,
  output logic [DW/8-1:0]   tstrb_m_o,
  output logic              tid_m_o,
  output logic              tvalid_m_o,
  input  logic              tready_m_i,
  output logic [CNT_W-1:0]  pair_cnt_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic              err_timeout_o
);

  state_e state_q, state_d;

  logic [DW-1:0]    hold_i_q, hold_i_d;
  logic [DW-1:0]    hold_q_q, hold_q_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic             tid_q, tid_d;
  logic             tvalid_q, tvalid_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             err_q, err_d;

  logic i_hs, q_hs, m_hs, clr, drop, tmo_expire, in_wait_q;

  // Lane readies already include ce, so the handshakes below are ce-qualified.
  assign i_hs      = tvalid_i_i & tready_i_o;
  assign q_hs      = tvalid_q_i & tready_q_o;
  assign m_hs      = ce & tvalid_q & tready_m_i;
  assign clr       = ce & clr_i;
  assign in_wait_q = ce & (state_q == ST_WAIT_Q);
  assign drop      = in_wait_q & ~q_hs & tmo_expire;

  axis_pair_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .aclk_s_i (aclk_s_i),
    .aresetn  (aresetn),
    .ce       (ce),
    .load_i   (i_hs),
    .inc_i    (in_wait_q & ~q_hs),
    .expire_o (tmo_expire)
  );

  always_ff @(posedge aclk_s_i or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_WAIT_I;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_I: if (i_hs) state_d = ST_WAIT_Q;
      ST_WAIT_Q: begin
        if (q_hs) begin
          state_d = ST_EMIT_I;
        end else if (drop) begin
          state_d = ST_WAIT_I;
        end
      end
      ST_EMIT_I: if (m_hs) state_d = ST_EMIT_Q;
      ST_EMIT_Q: if (m_hs) state_d = ST_WAIT_I;
      default:   state_d = ST_WAIT_I;
    endcase
  end

  // Readies are forced low while in reset so every output reads 0 there.
  always_comb begin
    tready_i_o = ce & aresetn & (state_q == ST_WAIT_I);
    tready_q_o = ce & aresetn & (state_q == ST_WAIT_Q);
  end

  always_comb begin
    hold_i_d   = hold_i_q;
    hold_q_d   = hold_q_q;
    tdata_d    = tdata_q;
    tid_d      = tid_q;
    tvalid_d   = tvalid_q;
    pair_cnt_d = pair_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;

    if (i_hs) hold_i_d = tdata_i_i;
    if (q_hs) begin
      hold_q_d = tdata_q_i;
      tdata_d  = hold_i_q;
      tid_d    = TID_I;
      tvalid_d = 1'b1;
    end else if (m_hs && (state_q == ST_EMIT_I)) begin
      tdata_d = hold_q_q;
      tid_d   = TID_Q;
    end else if (m_hs && (state_q == ST_EMIT_Q)) begin
      tvalid_d = 1'b0;
    end

    if (clr) begin
      pair_cnt_d = '0;
      drop_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      if (m_hs && (state_q == ST_EMIT_Q)) pair_cnt_d = pair_cnt_q + 1'b1;
      if (drop) begin
        err_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk_s_i or negedge aresetn) begin
    if (!aresetn) begin
      hold_i_q   <= '0;
      hold_q_q   <= '0;
      tdata_q    <= '0;
      tid_q      <= 1'b0;
      tvalid_q   <= 1'b0;
      pair_cnt_q <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      hold_i_q   <= hold_i_d;
      hold_q_q   <= hold_q_d;
      tdata_q    <= tdata_d;
      tid_q      <= tid_d;
      tvalid_q   <= tvalid_d;
      pair_cnt_q <= pair_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign tdata_m_o     = tdata_q;
  assign tstrb_m_o     = {(DW/8){tvalid_q}};
  assign tid_m_o       = tid_q;
  assign tvalid_m_o    = tvalid_q;
  assign pair_cnt_o    = pair_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_axis_iq_pair_scheduler.sv
// Directed bench for the I/Q pair scheduler: reset, pairing, back-pressure,
// timeout drop, Q-first ordering, clock-enable freeze and counter clear.
module tb_axis_iq_pair_scheduler;

  localparam int DW    = 16;
  localparam int CNT_W = 16;

  logic             aclk_s_i = 1'b0;
  logic             aresetn  = 1'b0;
  logic             ce       = 1'b1;
  logic             clr_i    = 1'b0;
  logic [DW-1:0]    tdata_i_i = '0;
  logic             tvalid_i_i = 1'b0;
  logic             tready_i_o;
  logic [DW-1:0]    tdata_q_i = '0;
  logic             tvalid_q_i = 1'b0;
  logic             tready_q_o;
  logic [DW-1:0]    tdata_m_o;
  logic [DW/8-1:0]  tstrb_m_o;
  logic             tid_m_o;
  logic             tvalid_m_o;
  logic             tready_m_i = 1'b0;
  logic [CNT_W-1:0] pair_cnt_o;
  logic [CNT_W-1:0] drop_cnt_o;
  logic             err_timeout_o;

  int checks = 0;
  int errors = 0;

  axis_iq_pair_scheduler #(.DW(DW), .TIMEOUT(64), .CNT_W(CNT_W)) dut (
    .aclk_s_i      (aclk_s_i),
    .aresetn       (aresetn),
    .ce            (ce),
    .clr_i         (clr_i),
    .tdata_i_i     (tdata_i_i),
    .tvalid_i_i    (tvalid_i_i),
    .tready_i_o    (tready_i_o),
    .tdata_q_i     (tdata_q_i),
    .tvalid_q_i    (tvalid_q_i),
    .tready_q_o    (tready_q_o),
    .tdata_m_o     (tdata_m_o),
    .tstrb_m_o     (tstrb_m_o),
    .tid_m_o       (tid_m_o),
    .tvalid_m_o    (tvalid_m_o),
    .tready_m_i    (tready_m_i),
    .pair_cnt_o    (pair_cnt_o),
    .drop_cnt_o    (drop_cnt_o),
    .err_timeout_o (err_timeout_o)
  );

  always #5 aclk_s_i = ~aclk_s_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge aclk_s_i);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] d, input logic id);
    chk({tag, "_valid"}, 32'(tvalid_m_o), 32'd1);
    chk({tag, "_data"}, 32'(tdata_m_o), 32'(d));
    chk({tag, "_tid"}, 32'(tid_m_o), 32'(id));
    chk({tag, "_strb"}, 32'(tstrb_m_o), 32'h3);
  endtask

  task automatic run_pair(input string tag, input logic [DW-1:0] i, input logic [DW-1:0] q,
                          input int exp_pairs);
    tdata_i_i = i; tvalid_i_i = 1'b1;
    tdata_q_i = q; tvalid_q_i = 1'b1;
    tready_m_i = 1'b1;
    chk({tag, "_bp_q"}, 32'(tready_q_o), 32'd0);
    tick();
    tvalid_i_i = 1'b0;
    chk({tag, "_rdy_q"}, 32'(tready_q_o), 32'd1);
    tick();
    tvalid_q_i = 1'b0;
    chk_out({tag, "_oi"}, i, 1'b0);
    tick();
    chk_out({tag, "_oq"}, q, 1'b1);
    tick();
    chk({tag, "_done_valid"}, 32'(tvalid_m_o), 32'd0);
    chk({tag, "_pairs"}, 32'(pair_cnt_o), 32'(exp_pairs));
    $display("pair %s I=%h Q=%h pairs=%0d", tag, i, q, pair_cnt_o);
  endtask

  initial begin
    // 1: reset
    repeat (3) @(posedge aclk_s_i);
    #1;
    chk("rst_rdy_i", 32'(tready_i_o), 32'd0);
    chk("rst_valid", 32'(tvalid_m_o), 32'd0);
    aresetn = 1'b1;
    tick();
    chk("rst_rdy_i_after", 32'(tready_i_o), 32'd1);
    chk("rst_rdy_q", 32'(tready_q_o), 32'd0);
    chk("rst_valid_after", 32'(tvalid_m_o), 32'd0);
    chk("rst_strb", 32'(tstrb_m_o), 32'd0);
    chk("rst_pairs", 32'(pair_cnt_o), 32'd0);
    chk("rst_drops", 32'(drop_cnt_o), 32'd0);
    chk("rst_err", 32'(err_timeout_o), 32'd0);

    // 2: basic pair
    run_pair("p1", 16'h1111, 16'h2222, 1);

    // 3: output stall in EMIT_I
    tready_m_i = 1'b0;
    tdata_i_i = 16'h1111; tvalid_i_i = 1'b1;
    tick();
    tvalid_i_i = 1'b0;
    tdata_q_i = 16'h2222; tvalid_q_i = 1'b1;
    tick();
    tvalid_q_i = 1'b0;
    tvalid_i_i = 1'b1;
    tvalid_q_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_out("stall", 16'h1111, 1'b0);
      chk("stall_rdy_i", 32'(tready_i_o), 32'd0);
      chk("stall_rdy_q", 32'(tready_q_o), 32'd0);
    end
    tvalid_i_i = 1'b0;
    tvalid_q_i = 1'b0;
    tready_m_i = 1'b1;
    tick();
    chk_out("stall_oq", 16'h2222, 1'b1);
    tick();
    chk("stall_pairs", 32'(pair_cnt_o), 32'd2);
    $display("pair stall I=1111 Q=2222 pairs=%0d", pair_cnt_o);

    // 4: timeout drop, then a clean pair
    tdata_i_i = 16'hAAAA; tvalid_i_i = 1'b1;
    tick();
    tvalid_i_i = 1'b0;
    for (int k = 0; k < 63; k++) begin
      tick();
      chk("tmo_novalid", 32'(tvalid_m_o), 32'd0);
    end
    chk("tmo_still_wait", 32'(tready_q_o), 32'd1);
    chk("tmo_nodrop_yet", 32'(drop_cnt_o), 32'd0);
    tick();
    chk("tmo_rdy_i", 32'(tready_i_o), 32'd1);
    chk("tmo_drops", 32'(drop_cnt_o), 32'd1);
    chk("tmo_err", 32'(err_timeout_o), 32'd1);
    chk("tmo_valid", 32'(tvalid_m_o), 32'd0);
    $display("drop I=AAAA drops=%0d", drop_cnt_o);
    run_pair("p_after_tmo", 16'h0001, 16'h0002, 3);

    // 5: Q arrives before I
    tdata_q_i = 16'h5555; tvalid_q_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("qfirst_bp", 32'(tready_q_o), 32'd0);
    end
    tdata_i_i = 16'h6666; tvalid_i_i = 1'b1;
    tick();
    tvalid_i_i = 1'b0;
    chk("qfirst_rdy_q", 32'(tready_q_o), 32'd1);
    tick();
    tvalid_q_i = 1'b0;
    chk_out("qfirst_oi", 16'h6666, 1'b0);
    tick();
    chk_out("qfirst_oq", 16'h5555, 1'b1);
    tick();
    chk("qfirst_pairs", 32'(pair_cnt_o), 32'd4);
    $display("pair qfirst I=6666 Q=5555 pairs=%0d", pair_cnt_o);

    // 6: ce low while in EMIT_Q
    tready_m_i = 1'b0;
    tdata_i_i = 16'h7777; tvalid_i_i = 1'b1;
    tick();
    tvalid_i_i = 1'b0;
    tdata_q_i = 16'h8888; tvalid_q_i = 1'b1;
    tick();
    tvalid_q_i = 1'b0;
    tready_m_i = 1'b1;
    tick();
    chk_out("ce_oq", 16'h8888, 1'b1);
    ce = 1'b0;
    tvalid_i_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("ce_frz", 16'h8888, 1'b1);
      chk("ce_rdy_i", 32'(tready_i_o), 32'd0);
      chk("ce_rdy_q", 32'(tready_q_o), 32'd0);
      chk("ce_pairs_frz", 32'(pair_cnt_o), 32'd4);
    end
    tvalid_i_i = 1'b0;
    ce = 1'b1;
    tick();
    chk("ce_valid_done", 32'(tvalid_m_o), 32'd0);
    chk("ce_pairs", 32'(pair_cnt_o), 32'd5);
    chk("ce_rdy_i_back", 32'(tready_i_o), 32'd1);
    $display("pair ce I=7777 Q=8888 pairs=%0d", pair_cnt_o);

    // clear coincident with a pair completion
    tready_m_i = 1'b1;
    tdata_i_i = 16'h0A0A; tvalid_i_i = 1'b1;
    tick();
    tvalid_i_i = 1'b0;
    tdata_q_i = 16'h0B0B; tvalid_q_i = 1'b1;
    tick();
    tvalid_q_i = 1'b0;
    tick();
    chk_out("clr_oq", 16'h0B0B, 1'b1);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    chk("clr_pairs", 32'(pair_cnt_o), 32'd0);
    chk("clr_drops", 32'(drop_cnt_o), 32'd0);
    chk("clr_err", 32'(err_timeout_o), 32'd0);
    chk("clr_valid", 32'(tvalid_m_o), 32'd0);
    $display("clear pairs=%0d drops=%0d", pair_cnt_o, drop_cnt_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
